// File: rtl/hazard_pkg.sv
// hazard_pkg: source tags (ALU/PC+8/MEM/HI-LO), width defaults and forward-select encoding shared by the hazard unit
package hazard_pkg;
  localparam int TW_DEF = 2;
  localparam int SRCW_DEF = 2;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_PC8 = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_HILO = 2'd3;
  localparam int FWD_NONE = 0;
endpackage

// File: rtl/hazard_lookup.sv
// hazard_lookup: youngest-first match of one read port (ra, ren) over N entries (v/wa/tnew/src) at stages OFF.., giving hit, sel, hit_tnew, hit_src
module hazard_lookup
  import hazard_pkg::*;
#(
  parameter int N = 3,
  parameter int OFF = 1,
  parameter int TW = TW_DEF,
  parameter int SRCW = SRCW_DEF,
  parameter int SELW = 2
) (
  input  logic [N-1:0]      v,
  input  logic [N*5-1:0]    wa,
  input  logic [N*TW-1:0]   tnew,
  input  logic [N*SRCW-1:0] src,
  input  logic [4:0]        ra,
  input  logic              ren,
  output logic              hit,
  output logic [SELW-1:0]   sel,
  output logic [TW-1:0]     hit_tnew,
  output logic [SRCW-1:0]   hit_src
);
  always_comb begin
    hit = 1'b0;
    sel = SELW'(FWD_NONE);
    hit_tnew = '0;
    hit_src = '0;
    for (int k = N - 1; k >= 0; k--)
      if (v[k] && wa[5*k+:5] == ra && ra != 5'd0 && ren) begin
        hit = 1'b1;
        sel = SELW'(k + OFF);
        hit_tnew = tnew[TW*k+:TW];
        hit_src = src[SRCW*k+:SRCW];
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard; D ports/write/md/flush in, stall, fwd_d/fwd_e selects+tags, md_busy, stall_cnt out
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_RP = 2,
  parameter int DEPTH = 3,
  parameter int TW = TW_DEF,
  parameter int SRCW = SRCW_DEF,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int SELW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RP*5-1:0]    d_ra,
  input  logic [NUM_RP*TW-1:0]   d_tuse,
  input  logic [NUM_RP-1:0]      d_ren,
  input  logic                   d_we,
  input  logic [4:0]             d_wa,
  input  logic [TW-1:0]          d_tnew,
  input  logic [SRCW-1:0]        d_src,
  input  logic                   d_md_start,
  input  logic                   d_md_div,
  input  logic                   d_md_acc,
  input  logic [DEPTH-1:0]       flush,
  output logic                   stall,
  output logic [NUM_RP*SELW-1:0] fwd_d,
  output logic [NUM_RP*SRCW-1:0] fwd_d_tag,
  output logic [NUM_RP*SELW-1:0] fwd_e,
  output logic [NUM_RP*SRCW-1:0] fwd_e_tag,
  output logic                   md_busy,
  output logic [31:0]            stall_cnt
);
  localparam int MDW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 2);
  logic [DEPTH-1:0] ev;
  logic [DEPTH*5-1:0] ewa;
  logic [DEPTH*TW-1:0] etn;
  logic [DEPTH*SRCW-1:0] esrc;
  logic [(DEPTH-1)*TW-1:0] etn_dec;
  logic [NUM_RP*5-1:0] e_ra;
  logic [NUM_RP-1:0] e_ren, port_stall;
  logic [MDW-1:0] md_cnt;
  logic md_in_e, md_issue, unused_flush;
  assign unused_flush = flush[DEPTH-1];
  assign md_busy = md_cnt != '0 || md_in_e;
  assign stall = |port_stall || (md_busy && (d_md_start || d_md_acc));
  assign md_issue = d_md_start && !stall && !flush[0];
  always_comb begin
    etn_dec = '0;
    for (int k = 0; k < DEPTH - 1; k++)
      etn_dec[TW*k+:TW] = etn[TW*k+:TW] == '0 ? '0 : etn[TW*k+:TW] - TW'(1);
  end
  for (genvar i = 0; i < NUM_RP; i++) begin : g_port
    logic d_hit, e_hit, d_fwd, e_fwd;
    logic [SELW-1:0] d_sel, e_sel;
    logic [TW-1:0] d_tn, e_tn;
    logic [SRCW-1:0] d_sk, e_sk;
    hazard_lookup #(.N(DEPTH), .OFF(1), .TW(TW), .SRCW(SRCW), .SELW(SELW)) u_d (
      .v(ev), .wa(ewa), .tnew(etn), .src(esrc), .ra(d_ra[5*i+:5]), .ren(d_ren[i]),
      .hit(d_hit), .sel(d_sel), .hit_tnew(d_tn), .hit_src(d_sk));
    hazard_lookup #(.N(DEPTH - 1), .OFF(2), .TW(TW), .SRCW(SRCW), .SELW(SELW)) u_e (
      .v(ev[DEPTH-1:1]), .wa(ewa[DEPTH*5-1:5]), .tnew(etn[DEPTH*TW-1:TW]), .src(esrc[DEPTH*SRCW-1:SRCW]),
      .ra(e_ra[5*i+:5]), .ren(e_ren[i]), .hit(e_hit), .sel(e_sel), .hit_tnew(e_tn), .hit_src(e_sk));
    assign d_fwd = d_hit && d_tn == '0;
    assign e_fwd = e_hit && e_tn == '0;
    assign port_stall[i] = d_hit && d_tn > d_tuse[TW*i+:TW];
    assign fwd_d[SELW*i+:SELW] = d_fwd ? d_sel : SELW'(FWD_NONE);
    assign fwd_d_tag[SRCW*i+:SRCW] = d_fwd ? d_sk : '0;
    assign fwd_e[SELW*i+:SELW] = e_fwd ? e_sel : SELW'(FWD_NONE);
    assign fwd_e_tag[SRCW*i+:SRCW] = e_fwd ? e_sk : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ev <= '0;
      ewa <= '0;
      etn <= '0;
      esrc <= '0;
      e_ra <= '0;
      e_ren <= '0;
      md_cnt <= '0;
      md_in_e <= 1'b0;
      stall_cnt <= '0;
    end else begin
      ev <= {ev[DEPTH-2:0] & ~flush[DEPTH-2:0], d_we && !stall && !flush[0] && d_wa != 5'd0};
      ewa <= {ewa[(DEPTH-1)*5-1:0], d_wa};
      etn <= {etn_dec, d_tnew};
      esrc <= {esrc[(DEPTH-1)*SRCW-1:0], d_src};
      e_ra <= stall || flush[0] ? '0 : d_ra;
      e_ren <= stall || flush[0] ? '0 : d_ren;
      md_cnt <= md_issue ? MDW'(d_md_div ? DIV_LAT + 1 : MUL_LAT + 1) :
                flush[0] && md_in_e ? '0 : md_cnt - MDW'(md_cnt != '0);
      md_in_e <= md_issue;
      stall_cnt <= stall_cnt + 32'(stall && stall_cnt != '1);
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with hand-computed expectations for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] d_ra;
  logic [3:0] d_tuse;
  logic [1:0] d_ren;
  logic d_we;
  logic [4:0] d_wa;
  logic [1:0] d_tnew, d_src;
  logic d_md_start, d_md_div, d_md_acc;
  logic [2:0] flush;
  logic stall, md_busy;
  logic [3:0] fwd_d, fwd_d_tag, fwd_e, fwd_e_tag;
  logic [31:0] stall_cnt;
  int n_chk = 0;
  int n_pass = 0;
  int n;
  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_ra(d_ra), .d_tuse(d_tuse), .d_ren(d_ren), .d_we(d_we), .d_wa(d_wa),
    .d_tnew(d_tnew), .d_src(d_src), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_acc(d_md_acc),
    .flush(flush), .stall(stall), .fwd_d(fwd_d), .fwd_d_tag(fwd_d_tag), .fwd_e(fwd_e), .fwd_e_tag(fwd_e_tag),
    .md_busy(md_busy), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic clear();
    d_ra = '0; d_tuse = '0; d_ren = '0; d_we = 0; d_wa = '0; d_tnew = '0; d_src = '0;
    d_md_start = 0; d_md_div = 0; d_md_acc = 0; flush = '0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [1:0] tn, input logic [1:0] s);
    d_we = 1; d_wa = a; d_tnew = tn; d_src = s;
  endtask
  task automatic rd(input int p, input logic [4:0] a, input logic [1:0] tu);
    d_ra[5*p+:5] = a; d_tuse[2*p+:2] = tu; d_ren[p] = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    clear();
    reset = 1;
    tick(); tick();
    #4;
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_fwd", {fwd_d, fwd_e}, 0);
    reset = 0;
    tick();
    // lw $1 tnew2 then reader tuse0: two stalls, then forward from W (stage 3) with MEM tag
    clear(); wr(1, 2, 2); tick();
    clear(); rd(0, 1, 0); #4; chk("lw_stall1", stall, 1); tick();
    #4; chk("lw_stall2", stall, 1); tick();
    #4; chk("lw_release", stall, 0); chk("lw_fwd", fwd_d, 3); chk("lw_tag", fwd_d_tag, 2); chk("lw_cnt", stall_cnt, 2); tick();
    // addu $2 tnew1 then beq tuse0: one stall then forward from M
    clear(); wr(2, 1, 0); tick();
    clear(); rd(0, 2, 0); #4; chk("beq_stall", stall, 1); tick();
    #4; chk("beq_release", stall, 0); chk("beq_fwd", fwd_d, 2); chk("beq_cnt", stall_cnt, 3); tick();
    // jal $31 then jr $31 on port 1: forward from E with PC8 tag
    clear(); wr(31, 0, 1); tick();
    clear(); rd(1, 31, 0); #4; chk("jr_stall", stall, 0); chk("jr_fwd", fwd_d, 4); chk("jr_tag", fwd_d_tag, 4); tick();
    // addu $3 tnew1 then consumer tuse1: no stall, resolved in E from stage 2
    clear(); wr(3, 1, 0); tick();
    clear(); rd(0, 3, 1); #4; chk("e_nostall", stall, 0); chk("e_dfwd", fwd_d, 0); tick();
    clear(); #4; chk("e_fwd", fwd_e, 2); chk("e_tag", fwd_e_tag, 0); tick();
    // two $3 writers (ALU older, MEM younger): youngest wins in both D and E
    clear(); wr(3, 1, 0); tick();
    clear(); wr(3, 1, 2); tick();
    clear(); rd(0, 3, 1); #4; chk("yng_nostall", stall, 0); tick();
    clear(); rd(1, 3, 0); #4;
    chk("yng_e_fwd", fwd_e, 2); chk("yng_e_tag", fwd_e_tag, 2);
    chk("yng_d_fwd", fwd_d, 8); chk("yng_d_tag", fwd_d_tag, 8); chk("yng_stall", stall, 0); tick();
    // write to $0 never creates a hazard
    clear(); wr(0, 2, 2); tick();
    clear(); rd(0, 0, 0); #4; chk("r0_stall", stall, 0); tick();
    // flush[0] kills the producer sitting in E
    clear(); wr(4, 2, 2); tick();
    clear(); flush = 3'b001; tick();
    clear(); rd(0, 4, 0); #4; chk("flush0_nostall", stall, 0); tick();
    // flush[1] targets stage 2, so a producer in E survives and still stalls
    clear(); wr(6, 2, 2); tick();
    clear(); flush = 3'b010; tick();
    clear(); rd(0, 6, 0); #4; chk("flush1_keep", stall, 1); tick();
    // mult then mflo: MUL_LAT+1 stall cycles, md_busy drops with the stall
    clear(); d_md_start = 1; #4; chk("mul_issue", stall, 0); tick();
    clear(); d_md_acc = 1; #4;
    n = 0;
    while (stall === 1'b1 && n < 40) begin n++; @(posedge clk); #5; end
    chk("mul_stalls", n, 6); chk("mul_busy_end", md_busy, 0); tick();
    // div uses DIV_LAT
    clear(); d_md_start = 1; d_md_div = 1; tick();
    clear(); d_md_acc = 1; #4;
    n = 0;
    while (stall === 1'b1 && n < 40) begin n++; @(posedge clk); #5; end
    chk("div_stalls", n, 11); chk("div_busy_end", md_busy, 0); tick();
    // mult flushed while in E: timer cleared, mfhi proceeds
    clear(); d_md_start = 1; tick();
    clear(); flush = 3'b001; #4; chk("mdf_busy", md_busy, 1); tick();
    clear(); d_md_acc = 1; #4; chk("mdf_stall", stall, 0); chk("mdf_idle", md_busy, 0); tick();
    // reset mid-div with a valid entry clears everything immediately
    clear(); d_md_start = 1; d_md_div = 1; tick();
    clear(); wr(7, 2, 2); tick();
    clear(); rd(0, 7, 0); #4; chk("pre_rst_stall", stall, 1); chk("pre_rst_busy", md_busy, 1);
    #1 reset = 1;
    #1;
    chk("mid_rst_stall", stall, 0); chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_fwd", {fwd_d, fwd_d_tag, fwd_e, fwd_e_tag}, 0); chk("mid_rst_cnt", stall_cnt, 0);
    tick();
    reset = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
